board_io_conditioner: RTL and testbench

//  Parametrised front end between board pins and the generator core. Per channel: N-stage

---
 rtl/io_cond_pkg.sv | 22 ++
 rtl/io_cond_channel.sv | 83 ++++++++
 rtl/board_io_conditioner.sv | 68 ++++++
 tb/tb_board_io_conditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_cond_pkg.sv
// rtl/io_cond_pkg.sv - shared constants and cycle-count helpers for the board I/O conditioner
package io_cond_pkg;

  // Default system clock, shared with the board tops.
  localparam int CLOCK_FREQUENCY = 50000000;

  // Whole clock cycles in a microsecond interval (integer MHz clocks).
  function automatic int cycles_from_us(input int freq, input int us);
    return (freq / 1000000) * us;
  endfunction

  // Whole clock cycles in a millisecond interval.
  function automatic int cycles_from_ms(input int freq, input int ms);
    return (freq / 1000) * ms;
  endfunction

  // Bits needed for a counter that must hold 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/io_cond_channel.sv
// rtl/io_cond_channel.sv - one sync+debounce lane with edge pulses; hold counter under IO_COND_LONG_PRESS_EN
module io_cond_channel
  import io_cond_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYC     = 1,
  parameter int   LP_CYC      = 1,
  parameter logic IDLE        = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int               DEB_W    = cnt_width(DEB_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DEB_W-1:0]       cnt;

  // Synchronizer chain; reset loads the idle pin level so no false edge appears.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= {SYNC_STAGES{IDLE}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  // Active-high view of the synchronized pin.
  assign s = sync_q[SYNC_STAGES-1] ^ IDLE;

  // Debounce: DEB_CYC consecutive differing samples flip the level; any match restarts.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        cnt   <= '0;
        level <= s;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef IO_COND_LONG_PRESS_EN
  localparam int              LP_W   = cnt_width(LP_CYC);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LP_CYC);

  logic [LP_W-1:0] hold;

  // Hold timer: counts while pressed, saturates at LP_CYC, fires once per press.
  always_ff @(posedge clock) begin
    if (reset || !level) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else if (hold != LP_MAX) begin
      hold       <= hold + 1'b1;
      long_press <= (hold == LP_MAX - 1'b1);
    end else begin
      long_press <= 1'b0;
    end
  end
`else
  // Hold timer not built; LP_CYC is kept so both builds share one parameter list.
  logic unused_lp;
  assign unused_lp  = (LP_CYC == 0);
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/board_io_conditioner.sv
// rtl/board_io_conditioner.sv - pin front end: debounced channels plus activity LED stretcher; option IO_COND_LONG_PRESS_EN
module board_io_conditioner
  import io_cond_pkg::*;
#(
  parameter int                  CLOCK_FREQ    = CLOCK_FREQUENCY,
  parameter int                  CHANNELS      = 2,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  DEBOUNCE_US   = 10000,
  parameter logic [CHANNELS-1:0] IDLE_LEVEL    = '0,
  parameter int                  STRETCH_MS    = 50,
  parameter int                  LONG_PRESS_MS = 2000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pin_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  input  logic                act_in,
  output logic                act_led
);

  localparam int               DEB_CYC  = cycles_from_us(CLOCK_FREQ, DEBOUNCE_US);
  localparam int               STR_CYC  = cycles_from_ms(CLOCK_FREQ, STRETCH_MS);
  localparam int               LP_CYC   = cycles_from_ms(CLOCK_FREQ, LONG_PRESS_MS);
  localparam int               STR_W    = cnt_width(STR_CYC);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STR_CYC);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    io_cond_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYC     (DEB_CYC),
      .LP_CYC      (LP_CYC),
      .IDLE        (IDLE_LEVEL[ch])
    ) u_lane (
      .clock      (clock),
      .reset      (reset),
      .pin        (pin_in[ch]),
      .level      (level_out[ch]),
      .rise       (rise_pulse[ch]),
      .fall       (fall_pulse[ch]),
      .long_press (long_pulse[ch])
    );
  end

  logic [SYNC_STAGES-1:0] act_sync;
  logic [STR_W-1:0]       str_cnt;

  // Activity line synchronizer; the line idles high so reset loads ones.
  always_ff @(posedge clock) begin
    if (reset) act_sync <= '1;
    else       act_sync <= {act_sync[SYNC_STAGES-2:0], act_in};
  end

  // Stretcher: every low sample reloads the on-time, otherwise count down to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      str_cnt <= '0;
      act_led <= 1'b0;
    end else begin
      if (!act_sync[SYNC_STAGES-1]) str_cnt <= STR_LOAD;
      else if (str_cnt != '0)       str_cnt <= str_cnt - 1'b1;
      act_led <= (str_cnt != '0);
    end
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// tb/tb_board_io_conditioner.sv - directed bench for board_io_conditioner (1 MHz, 5-cycle debounce)
module tb_board_io_conditioner;

  localparam int LAT = 7;  // SYNC_STAGES + DEB_CYC

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] pin_in;
  logic [1:0] level_out, rise_pulse, fall_pulse, long_pulse;
  logic       act_in;
  logic       act_led;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  board_io_conditioner #(
    .CLOCK_FREQ    (1000000),
    .CHANNELS      (2),
    .SYNC_STAGES   (2),
    .DEBOUNCE_US   (5),
    .IDLE_LEVEL    (2'b10),
    .STRETCH_MS    (1),
    .LONG_PRESS_MS (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pin_in     (pin_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .long_pulse (long_pulse),
    .act_in     (act_in),
    .act_led    (act_led)
  );

  typedef struct {
    logic [1:0] pin;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t vecs[$];

  int bad, rises, falls, other, rise_at, first, last, high, gaps, lp_cnt, lp_at;
  logic bounce [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // n cycles of a held pin pattern; the level change lands on the LAT-th cycle.
  task automatic add_seg(input logic [1:0] pin, input int n, input logic [1:0] lb,
                         input logic [1:0] la, input logic [1:0] r, input logic [1:0] f);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.pin   = pin;
      v.level = (i < LAT - 1) ? lb : la;
      v.rise  = (i == LAT - 1) ? r : 2'b00;
      v.fall  = (i == LAT - 1) ? f : 2'b00;
      vecs.push_back(v);
    end
  endtask

  initial begin
    add_seg(2'b01, 10, 2'b00, 2'b11, 2'b11, 2'b00);
    add_seg(2'b10, 10, 2'b11, 2'b00, 2'b00, 2'b11);
    add_seg(2'b11, 10, 2'b00, 2'b01, 2'b01, 2'b00);
    add_seg(2'b10, 10, 2'b01, 2'b00, 2'b00, 2'b01);
    add_seg(2'b00, 10, 2'b00, 2'b10, 2'b10, 2'b00);
    add_seg(2'b10, 10, 2'b10, 2'b00, 2'b00, 2'b10);

    // Reset and idle
    reset  = 1'b1;
    pin_in = 2'b10;
    act_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset_outs%0d", i),
          32'({level_out, rise_pulse, fall_pulse, long_pulse, act_led}), 32'd0);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({level_out, rise_pulse, fall_pulse, long_pulse, act_led} !== 9'd0) bad++;
    end
    chk("idle_100", bad, 0);

    // Clean presses and releases, both polarities, channels together and alone
    for (int i = 0; i < vecs.size(); i++) begin
      pin_in = vecs[i].pin;
      step();
      chk($sformatf("vec%0d", i),
          32'({level_out, rise_pulse, fall_pulse, long_pulse, act_led}),
          32'({vecs[i].level, vecs[i].rise, vecs[i].fall, 2'b00, 1'b0}));
    end

    // Bounce on channel 0 then stable press
    rises = 0; falls = 0; other = 0; rise_at = -1;
    for (int i = 0; i < 8; i++) begin
      pin_in = {1'b1, bounce[i]};
      step();
      if (rise_pulse[0]) rises++;
      if (fall_pulse[0]) falls++;
    end
    for (int j = 0; j < 20; j++) begin
      pin_in = 2'b11;
      step();
      if (rise_pulse[0]) begin rises++; rise_at = j; end
      if (fall_pulse[0]) falls++;
      if (rise_pulse[1] || fall_pulse[1]) other++;
    end
    chk("bounce_rises", rises, 1);
    chk("bounce_rise_at", rise_at, LAT - 1);
    chk("bounce_falls", falls, 0);
    chk("bounce_ch1_quiet", other, 0);
    chk("bounce_level", 32'(level_out), 32'd1);
    falls = 0;
    for (int j = 0; j < 12; j++) begin
      pin_in = 2'b10;
      step();
      if (fall_pulse[0]) falls++;
    end
    chk("bounce_release_falls", falls, 1);
    chk("bounce_release_level", 32'(level_out), 32'd0);

    // Activity stretcher: single low sample
    high = 0; first = -1; last = -1;
    for (int i = 0; i < 1200; i++) begin
      act_in = (i == 0) ? 1'b0 : 1'b1;
      step();
      if (act_led) begin high++; if (first < 0) first = i; last = i; end
    end
    chk("act_single_len", high, 1000);
    chk("act_single_contig", last - first + 1, 1000);
    chk("act_single_start", 32'(first >= 0 && first <= 4), 32'd1);

    // Retrigger at cycle 500 extends the on-time
    high = 0; first = -1; last = -1;
    for (int i = 0; i < 2000; i++) begin
      act_in = (i == 0 || i == 500) ? 1'b0 : 1'b1;
      step();
      if (act_led) begin high++; if (first < 0) first = i; last = i; end
    end
    chk("act_retrig_len", high, 1500);
    chk("act_retrig_contig", last - first + 1, 1500);

    // Line held low keeps the LED lit
    first = -1; gaps = 0;
    for (int i = 0; i < 1500; i++) begin
      act_in = 1'b0;
      step();
      if (act_led && first < 0) first = i;
      if (first >= 0 && !act_led) gaps++;
    end
    chk("act_held_lit", 32'(first >= 0), 32'd1);
    chk("act_held_gaps", gaps, 0);
    for (int i = 0; i < 1100; i++) begin
      act_in = 1'b1;
      step();
    end
    chk("act_held_off", 32'(act_led), 32'd0);

    // Long press: 1500-cycle hold, then 500-cycle hold
    lp_cnt = 0; lp_at = -1; other = 0;
    for (int i = 0; i < 1520; i++) begin
      pin_in = (i < 1500) ? 2'b11 : 2'b10;
      step();
      if (long_pulse[0]) begin lp_cnt++; lp_at = i; end
      if (long_pulse[1]) other++;
    end
`ifdef IO_COND_LONG_PRESS_EN
    chk("long_count", lp_cnt, 1);
    chk("long_at", lp_at, LAT - 1 + 1000);
`else
    chk("long_count_disabled", lp_cnt, 0);
`endif
    chk("long_ch1_quiet", other, 0);
    lp_cnt = 0;
    for (int i = 0; i < 520; i++) begin
      pin_in = (i < 500) ? 2'b11 : 2'b10;
      step();
      if (long_pulse != 2'b00) lp_cnt++;
    end
    chk("long_short_press", lp_cnt, 0);

    // Reset during debounce discards progress
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      pin_in = 2'b11;
      step();
      if (rise_pulse != 2'b00) rises++;
    end
    reset = 1'b1;
    step();
    chk("midreset_outs", 32'({level_out, rise_pulse, fall_pulse, long_pulse, act_led}), 32'd0);
    reset = 1'b0;
    rise_at = -1;
    for (int j = 0; j < 12; j++) begin
      step();
      if (rise_pulse[0]) begin rises++; if (rise_at < 0) rise_at = j; end
    end
    chk("midreset_rises", rises, 1);
    chk("midreset_rise_at", rise_at, LAT - 1);
    chk("midreset_level", 32'(level_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
